// File: rtl/riscv_pkg.sv
// Shared SimplyTRV core constants: word width, zero-register index and RV32I/RV32E register counts.
// Pure declarations; no logic, no latency, no flow control.
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_ZERO = 0;
  localparam int NREGS_I  = 32;
  localparam int NREGS_E  = 16;

  // Address width for a register count; a single register still needs one address bit.
  function automatic int rf_addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register file access bundle: one write port plus NRD packed read ports.
// Decode/writeback side is the master; the register file is the slave.
interface reg_file_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);

  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRD-1:0]      ren;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;

  modport master (
    output we,
    output waddr,
    output wdata,
    output ren,
    output raddr,
    input  rdata
  );

  modport slave (
    input  we,
    input  waddr,
    input  wdata,
    input  ren,
    input  raddr,
    output rdata
  );

endinterface

// File: rtl/rf_read_port.sv
// One register file read port: word select, range/zero/bypass priority and optional output register.
// Latency 0 (RD_REG=0) or 1 cycle gated by ren (RD_REG=1); never stalls, no backpressure.
module rf_read_port
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NREGS    = NREGS_I,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit RD_REG   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREGS*XLEN-1:0] words,
  input  logic                  wr_ok,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  ren,
  input  logic [AW-1:0]         raddr,
  output logic [XLEN-1:0]       rdata
);

  logic [XLEN-1:0] sel;
  logic [XLEN-1:0] rd_val;
  logic            in_range;
  logic            is_zero;
  logic            fwd_hit;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (raddr == AW'(i)) begin
        sel = words[i*XLEN +: XLEN];
      end
    end
  end

  assign in_range = (32'(raddr) < 32'(NREGS));
  assign is_zero  = ZERO_REG && (raddr == AW'(REG_ZERO));
  // wr_ok already excludes ignored writes, so a hit never forwards into x0 or out of range.
  assign fwd_hit  = BYPASS && wr_ok && (waddr == raddr);

  always_comb begin
    rd_val = '0;
    if (!in_range) begin
      rd_val = '0;
    end else if (is_zero) begin
      rd_val = '0;
    end else if (fwd_hit) begin
      rd_val = wdata;
    end else begin
      rd_val = sel;
    end
  end

  generate
    if (RD_REG) begin : g_rd_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata <= '0;
        end else if (ren) begin
          rdata <= rd_val;
        end
      end
    end else begin : g_rd_comb
      logic unused_rd_ctrl;
      assign unused_rd_ctrl = ^{clk, rst, ren};
      assign rdata          = rd_val;
    end
  endgenerate

endmodule

// File: rtl/reg_file.sv
// Parametrised integer register file: NREGS x XLEN storage, one write port, NRD read ports.
// Read latency 0 or 1 cycle (RD_REG); writes land on the next rising clk; no backpressure.
module reg_file
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NREGS    = NREGS_I,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit RD_REG   = 1'b0
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  localparam int AW = rf_addr_width(NREGS);

  logic [XLEN-1:0]       regs [NREGS];
  logic [NREGS*XLEN-1:0] words;
  logic                  wr_ok;

  assign wr_ok = bus.we
               && (32'(bus.waddr) < 32'(NREGS))
               && !(ZERO_REG && (bus.waddr == AW'(REG_ZERO)));

  generate
    for (genvar g = 0; g < NREGS; g++) begin : g_word
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs[g] <= '0;
        end else if (wr_ok && (bus.waddr == AW'(g))) begin
          regs[g] <= bus.wdata;
        end
      end
      assign words[g*XLEN +: XLEN] = regs[g];
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
      rf_read_port #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .RD_REG   (RD_REG)
      ) u_rd (
        .clk   (clk),
        .rst   (rst),
        .words (words),
        .wr_ok (wr_ok),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .ren   (bus.ren[p]),
        .raddr (bus.raddr[p*AW +: AW]),
        .rdata (bus.rdata[p*XLEN +: XLEN])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: four parameterisations share one stimulus stream and are checked against an array model.
module tb_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [1:0]  ren;
  logic [4:0]  ra0;
  logic [4:0]  ra1;

  // u0 default, u1 20 regs / no x0 / no bypass, u2 registered reads, u3 RV32E
  reg_file_if #(.XLEN(32), .AW(5), .NRD(2)) bus0 ();
  reg_file_if #(.XLEN(32), .AW(5), .NRD(2)) bus1 ();
  reg_file_if #(.XLEN(32), .AW(5), .NRD(2)) bus2 ();
  reg_file_if #(.XLEN(32), .AW(4), .NRD(2)) bus3 ();

  assign bus0.we = we;  assign bus0.waddr = wa;       assign bus0.wdata = wd;
  assign bus0.ren = ren; assign bus0.raddr = {ra1, ra0};
  assign bus1.we = we;  assign bus1.waddr = wa;       assign bus1.wdata = wd;
  assign bus1.ren = ren; assign bus1.raddr = {ra1, ra0};
  assign bus2.we = we;  assign bus2.waddr = wa;       assign bus2.wdata = wd;
  assign bus2.ren = ren; assign bus2.raddr = {ra1, ra0};
  assign bus3.we = we;  assign bus3.waddr = wa[3:0];  assign bus3.wdata = wd;
  assign bus3.ren = ren; assign bus3.raddr = {ra1[3:0], ra0[3:0]};

  reg_file #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1), .RD_REG(1'b0))
    u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  reg_file #(.XLEN(32), .NREGS(20), .NRD(2), .ZERO_REG(1'b0), .BYPASS(1'b0), .RD_REG(1'b0))
    u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  reg_file #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1), .RD_REG(1'b1))
    u2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  reg_file #(.XLEN(32), .NREGS(16), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1), .RD_REG(1'b0))
    u3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  // Reference model: plain storage arrays per instance plus u2's output registers.
  logic [31:0] mem [4][32];
  logic [31:0] mrd [2];
  int cfg_n  [4] = '{32, 20, 32, 16};
  int cfg_aw [4] = '{5, 5, 5, 4};
  bit cfg_z  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit cfg_b  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  int checks = 0;
  int errors = 0;

  function automatic int effa(input int k, input int a);
    return a & ((1 << cfg_aw[k]) - 1);
  endfunction

  function automatic bit m_wok(input int k);
    int a;
    a = effa(k, int'(wa));
    return we && (a < cfg_n[k]) && !(cfg_z[k] && a == 0);
  endfunction

  function automatic logic [31:0] m_val(input int k, input int ra);
    int a;
    a = effa(k, ra);
    if (a >= cfg_n[k]) return 32'h0;
    if (cfg_z[k] && a == 0) return 32'h0;
    if (cfg_b[k] && m_wok(k) && effa(k, int'(wa)) == a) return wd;
    return mem[k][a];
  endfunction

  function automatic logic [31:0] m_exp(input int k, input int p);
    if (k == 2) return mrd[p];
    return m_val(k, (p == 1) ? int'(ra1) : int'(ra0));
  endfunction

  function automatic logic [31:0] get_rd(input int k, input int p);
    logic [63:0] r;
    case (k)
      0:       r = bus0.rdata;
      1:       r = bus1.rdata;
      2:       r = bus2.rdata;
      default: r = bus3.rdata;
    endcase
    return (p == 1) ? r[63:32] : r[31:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 32; a++)
        mem[k][a] = 32'h0;
    mrd[0] = 32'h0;
    mrd[1] = 32'h0;
  endtask

  // Advance one clock: apply the edge to the model, then return at the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int p = 0; p < 2; p++)
      if (ren[p]) mrd[p] = m_val(2, (p == 1) ? int'(ra1) : int'(ra0));
    for (int k = 0; k < 4; k++)
      if (m_wok(k)) mem[k][effa(k, int'(wa))] = wd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ren = '0; ra0 = '0; ra1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (get_rd(2, p) !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdreg p=%0d: got %h expected %h", p, get_rd(2, p), 32'h0);
      end
    end
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(31 - a);
      #1;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (get_rd(0, p) !== 32'h0) begin
          errors++;
          $display("FAIL reset_read a=%0d p=%0d: got %h expected %h", a, p, get_rd(0, p), 32'h0);
        end
      end
      tick();
    end
  endtask

  task automatic test_sweep();
    logic [31:0] e0, e1;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i) * 32'h0101_0101;
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i);
      #1;
      e0 = 32'(i) * 32'h0101_0101;
      e1 = (i == 31) ? 32'h0 : 32'(31 - i) * 32'h0101_0101;
      checks++;
      if (get_rd(0, 0) !== e0) begin
        errors++;
        $display("FAIL sweep_p0 i=%0d: got %h expected %h", i, get_rd(0, 0), e0);
      end
      checks++;
      if (get_rd(0, 1) !== e1) begin
        errors++;
        $display("FAIL sweep_p1 i=%0d: got %h expected %h", i, get_rd(0, 1), e1);
      end
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (get_rd(1, p) !== m_exp(1, p)) begin
          errors++;
          $display("FAIL sweep_nregs20 i=%0d p=%0d: got %h expected %h", i, p, get_rd(1, p), m_exp(1, p));
        end
      end
      tick();
    end
  endtask

  task automatic test_zero();
    we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF; ra0 = 5'd0; ra1 = 5'd0; ren = 2'b00;
    #1;
    checks++;
    if (get_rd(0, 0) !== 32'h0) begin
      errors++; $display("FAIL zero_same_cycle: got %h expected %h", get_rd(0, 0), 32'h0);
    end
    checks++;
    if (get_rd(1, 0) !== 32'h0) begin
      errors++; $display("FAIL nozero_before_edge: got %h expected %h", get_rd(1, 0), 32'h0);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (get_rd(0, 0) !== 32'h0) begin
      errors++; $display("FAIL zero_after_edge: got %h expected %h", get_rd(0, 0), 32'h0);
    end
    checks++;
    if (get_rd(1, 1) !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL nozero_after_edge: got %h expected %h", get_rd(1, 1), 32'hDEAD_BEEF);
    end
    tick();
    checks++;
    if (get_rd(0, 1) !== 32'h0) begin
      errors++; $display("FAIL zero_later: got %h expected %h", get_rd(0, 1), 32'h0);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd5; wd = 32'hCAFE_0005; ra0 = 5'd5; ra1 = 5'd5;
    #1;
    checks++;
    if (get_rd(0, 0) !== 32'hCAFE_0005) begin
      errors++; $display("FAIL bypass_fwd: got %h expected %h", get_rd(0, 0), 32'hCAFE_0005);
    end
    checks++;
    if (get_rd(1, 0) !== 32'h0505_0505) begin
      errors++; $display("FAIL nobypass_old: got %h expected %h", get_rd(1, 0), 32'h0505_0505);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (get_rd(1, 0) !== 32'hCAFE_0005) begin
      errors++; $display("FAIL nobypass_new: got %h expected %h", get_rd(1, 0), 32'hCAFE_0005);
    end
    tick();
  endtask

  task automatic test_regread();
    ren = 2'b00; we = 1'b1; wa = 5'd7; wd = 32'h1234_5678;
    tick();
    we = 1'b0; ren = 2'b11; ra0 = 5'd7; ra1 = 5'd7;
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (get_rd(2, p) !== 32'h1234_5678) begin
        errors++; $display("FAIL rdreg_load p=%0d: got %h expected %h", p, get_rd(2, p), 32'h1234_5678);
      end
    end
    ren = 2'b00; ra0 = 5'd3; ra1 = 5'd9;
    tick();
    tick();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (get_rd(2, p) !== 32'h1234_5678) begin
        errors++; $display("FAIL rdreg_hold p=%0d: got %h expected %h", p, get_rd(2, p), 32'h1234_5678);
      end
    end
    we = 1'b1; wa = 5'd8; wd = 32'h0BAD_F00D; ren = 2'b01; ra0 = 5'd8; ra1 = 5'd8;
    tick();
    we = 1'b0; ren = 2'b00;
    checks++;
    if (get_rd(2, 0) !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL rdreg_rdw: got %h expected %h", get_rd(2, 0), 32'h0BAD_F00D);
    end
    checks++;
    if (get_rd(2, 1) !== 32'h1234_5678) begin
      errors++; $display("FAIL rdreg_rdw_hold: got %h expected %h", get_rd(2, 1), 32'h1234_5678);
    end
  endtask

  task automatic test_rv32e();
    we = 1'b1; wa = 5'd15; wd = 32'hA5A5_A5A5; ren = 2'b00;
    tick();
    we = 1'b0; ra0 = 5'd15; ra1 = 5'd31; ren = 2'b11;
    #1;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (get_rd(3, p) !== 32'hA5A5_A5A5) begin
        errors++; $display("FAIL rv32e_x15 p=%0d: got %h expected %h", p, get_rd(3, p), 32'hA5A5_A5A5);
      end
    end
    tick();
    ren = 2'b00;
    #2;
    checks++;
    if (get_rd(2, 0) !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL rdreg_prereset: got %h expected %h", get_rd(2, 0), 32'hA5A5_A5A5);
    end
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (get_rd(3, 0) !== 32'h0) begin
      errors++; $display("FAIL async_rst_rv32e: got %h expected %h", get_rd(3, 0), 32'h0);
    end
    checks++;
    if (get_rd(0, 0) !== 32'h0) begin
      errors++; $display("FAIL async_rst_storage: got %h expected %h", get_rd(0, 0), 32'h0);
    end
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (get_rd(2, p) !== 32'h0) begin
        errors++; $display("FAIL async_rst_rdreg p=%0d: got %h expected %h", p, get_rd(2, p), 32'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom);
      wa  = 5'($urandom);
      wd  = $urandom;
      ren = 2'($urandom);
      ra0 = 5'($urandom);
      ra1 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) ra0 = wa;
      if ($urandom_range(0, 3) == 0) ra1 = wa;
      #1;
      for (int k = 0; k < 4; k++) begin
        for (int p = 0; p < 2; p++) begin
          checks++;
          if (get_rd(k, p) !== m_exp(k, p)) begin
            errors++;
            $display("FAIL random n=%0d k=%0d p=%0d: got %h expected %h", n, k, p, get_rd(k, p), m_exp(k, p));
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_zero();
    test_bypass();
    test_regread();
    test_rv32e();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
Parametrised integer register file for the SimplyTRV core, replacing the fixed 32-word, 32:1 word selector with real storage.
- NREGS words of XLEN bits.
- NRD independent read ports and one write port.
- Optional hard-wired zero register.
- Optional write-to-read bypass.
- Optional registered (pipelined) reads.

Sits between decode (read addresses) and writeback (write port).

Parameters:
- XLEN, 32, data word width in bits.
- NREGS, 32, number of architectural registers (≥2, need not be a power of 2).
- AW, $clog2(NREGS), address width; derived, never overridden.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to the read address is forwarded to that read port.
- RD_REG, 0, 0 means combinational read data; 1 means read data registered, 1-cycle latency.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- ren  in  NRD  per-port read enable; used only when RD_REG=1.
- raddr  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NRD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].

Behaviour:
- Reset: asserting rst immediately clears every storage word to 0. With RD_REG=1 it also clears every rdata register to 0. Reset is asynchronous and takes priority over any write in progress. After deassertion, the first write takes effect on the next rising clk.
- Write:
  - On rising clk with we=1, regs[waddr] <= wdata.
  - The write is ignored if waddr ≥ NREGS.
  - The write is ignored if ZERO_REG=1 and waddr=0.
- Read value v_i for port i, evaluated every cycle:
  - 0 if raddr_i ≥ NREGS.
  - Else 0 if ZERO_REG=1 and raddr_i=0.
  - Else wdata if BYPASS=1, we=1, waddr=raddr_i and the write is not ignored.
  - Else regs[raddr_i].
- RD_REG=0: rdata_i = v_i combinationally, zero latency.
  - With BYPASS=0, a same-cycle write becomes visible only after the edge.
- RD_REG=1: on rising clk, rdata_i <= v_i if ren_i=1; otherwise rdata_i holds.
  - Latency is 1 cycle.
  - Bypass resolves a read/write collision in the same cycle, so read-during-write returns the new data.
- All ports are independent. Any number of ports may read the same address simultaneously, including the address being written.
- No internal state machine. Storage plus the optional output pipeline register are the only sequential elements.

Decomposition:
- Package riscv_pkg holds:
  - XLEN default 32.
  - REG_ZERO = 0.
  - NREGS_I = 32 and NREGS_E = 16 (RV32I / RV32E).
- Sub-module rf_read_port, instantiated NRD times via generate. It contains:
  - the NREGS:1 word select;
  - the zero/range/bypass priority logic;
  - the optional output register (RD_REG) with ren.
- reg_file keeps the storage array and write decode only.

Test Plan:
1. Default parameters. Reset, then read all 32 addresses on both ports → every rdata = 0.
2. Write regs[i] = i*0x01010101 for i=1..31, then sweep raddr0=i and raddr1=31-i:
   - rdata0 = i*0x01010101;
   - rdata1 = (31-i)*0x01010101, except i=31 where rdata1 = 0 (x0).
3. we=1, waddr=0, wdata=0xDEADBEEF, then read x0 → 0 in the same cycle and all later cycles.
   - Repeat with ZERO_REG=0 → 0xDEADBEEF, visible after the edge.
4. BYPASS=1, RD_REG=0: we=1, waddr=5, wdata=0xCAFE0005, raddr0=5 in the same cycle → rdata0 = 0xCAFE0005 before the edge.
   - With BYPASS=0 → old value before the edge, 0xCAFE0005 after.
5. RD_REG=1: write x7=0x12345678, then ren=2'b11 with raddr0=raddr1=7 → both ports show 0x12345678 one cycle later.
   - Then ren=0 with raddr changed → both ports hold 0x12345678.
6. NREGS=16 (RV32E), AW=4: write/read x15 = 0xA5A5A5A5 → data returned correctly.
   - Assert rst asynchronously mid-cycle → rdata and storage read 0 without waiting for a clock edge.
